// File: rtl/tea_pkg.sv
// Shared widths and FSM encoding for the TEA key-search tail stage.
package tea_pkg;

  localparam int unsigned TEA_BLOCK_W = 64;
  localparam int unsigned TEA_KEY_W   = 128;
  localparam int unsigned LFSR_W      = 31;
  localparam int unsigned RESULT_W    = LFSR_W + TEA_KEY_W;
  localparam int unsigned CNT_W       = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StSearch = ST_SEARCH,
    StDrain  = ST_DRAIN,
    StDone   = ST_DONE
  } state_e;

endpackage

// File: rtl/tea_match_collector_if.sv
// Control, candidate-stream and result-stream signals of the match collector.
interface tea_match_collector_if;
  import tea_pkg::*;

  logic                   start;
  logic [CNT_W-1:0]       max_count;
  logic [TEA_BLOCK_W-1:0] expected_plain;
  logic                   in_valid;
  logic [TEA_BLOCK_W-1:0] in_data;
  logic [LFSR_W-1:0]      in_lfsr_state;
  logic [TEA_KEY_W-1:0]   in_key;
  logic                   busy;
  logic                   done;
  logic [CNT_W-1:0]       tested;
  logic                   res_valid;
  logic [LFSR_W-1:0]      res_lfsr;
  logic [TEA_KEY_W-1:0]   res_key;
  logic                   res_pop;
  logic                   overflow;

  modport master (
    output start, max_count, expected_plain, in_valid, in_data, in_lfsr_state, in_key, res_pop,
    input  busy, done, tested, res_valid, res_lfsr, res_key, overflow
  );

  modport slave (
    input  start, max_count, expected_plain, in_valid, in_data, in_lfsr_state, in_key, res_pop,
    output busy, done, tested, res_valid, res_lfsr, res_key, overflow
  );

endinterface

// File: rtl/tea_result_fifo.sv
// Synchronous first-word-fall-through FIFO for matching {lfsr,key} results.
module tea_result_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 159
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  // Pointer next-state: clear wins over push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/tea_match_collector.sv
// Tail of the TEA decrypt pipeline: compares blocks to the known plaintext, counts
// candidates, buffers matches for the host and sequences the search.
module tea_match_collector
  import tea_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter bit          STOP_ON_FIRST = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  tea_match_collector_if.slave  bus_io
);

  state_e                 state_q, state_d;
  logic [TEA_BLOCK_W-1:0] expected_q, expected_d;
  logic [CNT_W-1:0]       max_q, max_d;
  logic [CNT_W-1:0]       tested_q, tested_d;
  logic                   overflow_q, overflow_d;
  logic                   match_q;
  logic [RESULT_W-1:0]    cand_q;
  logic                   start_ok, stop_now, accept, last_cand;
  logic                   fifo_full, fifo_empty;
  logic [RESULT_W-1:0]    fifo_head;

  assign start_ok  = bus_io.start && (state_q == StIdle || state_q == StDone);
  // With STOP_ON_FIRST the push edge ends the search, so the candidate offered on
  // that same edge is refused rather than counted.
  assign stop_now  = STOP_ON_FIRST && match_q && (state_q == StSearch || state_q == StDrain);
  assign accept    = bus_io.in_valid && (state_q == StSearch) && !stop_now;
  assign last_cand = (({1'b0, tested_q} + 33'd1) == {1'b0, max_q});

  // Next-state for FSM, counter, latched config and sticky overflow.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    max_d      = max_q;
    tested_d   = tested_q;
    overflow_d = overflow_q;
    if (match_q && fifo_full && !bus_io.res_pop) overflow_d = 1'b1;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus_io.start) begin
          expected_d = bus_io.expected_plain;
          max_d      = bus_io.max_count;
          tested_d   = '0;
          overflow_d = 1'b0;
          state_d    = (bus_io.max_count == '0) ? StDrain : StSearch;
        end
      end
      StSearch: begin
        if (stop_now) begin
          state_d = StDone;
        end else if (accept) begin
          if (tested_q != {CNT_W{1'b1}}) tested_d = tested_q + 1'b1;
          if (last_cand) state_d = StDrain;
        end
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // State, counter and config registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      expected_q <= '0;
      max_q      <= '0;
      tested_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      max_q      <= max_d;
      tested_q   <= tested_d;
      overflow_q <= overflow_d;
    end
  end

  // Registered compare stage; its result is pushed one edge later.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      match_q <= 1'b0;
      cand_q  <= '0;
    end else begin
      match_q <= accept && (bus_io.in_data == expected_q);
      cand_q  <= {bus_io.in_lfsr_state, bus_io.in_key};
    end
  end

  tea_result_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (RESULT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (start_ok),
    .push_i  (match_q),
    .data_i  (cand_q),
    .pop_i   (bus_io.res_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus_io.busy      = (state_q == StSearch) || (state_q == StDrain);
  assign bus_io.done      = (state_q == StDone);
  assign bus_io.tested    = tested_q;
  assign bus_io.res_valid = !fifo_empty;
  assign bus_io.res_lfsr  = fifo_head[RESULT_W-1:TEA_KEY_W];
  assign bus_io.res_key   = fifo_head[TEA_KEY_W-1:0];
  assign bus_io.overflow  = overflow_q;

endmodule

// File: tb/tb_tea_match_collector.sv
// Bench for tea_match_collector: directed stimulus, result entries checked by
// per-DUT scoreboards, status flags checked inline.
module tb_tea_match_collector;

  localparam logic [63:0] EXP = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [158:0] exp0 [$];
  logic [158:0] exp1 [$];

  always #5 clk = ~clk;

  tea_match_collector_if if0 ();
  tea_match_collector_if if1 ();

  tea_match_collector #(.FIFO_DEPTH(4), .STOP_ON_FIRST(1'b0)) dut0 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_io  (if0)
  );

  tea_match_collector #(.FIFO_DEPTH(4), .STOP_ON_FIRST(1'b1)) dut1 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_io  (if1)
  );

  task automatic chk(input string name, input logic [158:0] act, input logic [158:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every accepted pop is compared with the queued entry.
  always @(negedge clk) begin
    if (!rst && if0.res_valid && if0.res_pop) begin
      if (exp0.size() == 0) chk("dut0_unexpected_pop", {if0.res_lfsr, if0.res_key}, '0);
      else chk("dut0_pop_entry", {if0.res_lfsr, if0.res_key}, exp0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && if1.res_valid && if1.res_pop) begin
      if (exp1.size() == 0) chk("dut1_unexpected_pop", {if1.res_lfsr, if1.res_key}, '0);
      else chk("dut1_pop_entry", {if1.res_lfsr, if1.res_key}, exp1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic start0(input logic [31:0] maxc);
    if0.max_count = maxc;
    if0.expected_plain = EXP;
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
  endtask

  initial begin
    {if0.start, if0.max_count, if0.expected_plain, if0.in_valid, if0.in_data} = '0;
    {if0.in_lfsr_state, if0.in_key, if0.res_pop} = '0;
    {if1.start, if1.max_count, if1.expected_plain, if1.in_valid, if1.in_data} = '0;
    {if1.in_lfsr_state, if1.in_key, if1.res_pop} = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 159'(if0.busy), 159'(0));
    chk("rst_done", 159'(if0.done), 159'(0));
    chk("rst_tested", 159'(if0.tested), 159'(0));
    chk("rst_res_valid", 159'(if0.res_valid), 159'(0));
    chk("rst_overflow", 159'(if0.overflow), 159'(0));

    // 1: five non-matching candidates
    start0(32'd5);
    chk("t1_busy_search", 159'(if0.busy), 159'(1));
    for (int i = 0; i < 5; i++) begin
      if0.in_valid = 1'b1;
      if0.in_data = 64'(i);
      tick();
    end
    if0.in_valid = 1'b0;
    chk("t1_tested", 159'(if0.tested), 159'(5));
    chk("t1_busy_drain", 159'(if0.busy), 159'(1));
    chk("t1_not_done_drain", 159'(if0.done), 159'(0));
    tick();
    chk("t1_done", 159'(if0.done), 159'(1));
    chk("t1_res_valid", 159'(if0.res_valid), 159'(0));
    chk("t1_overflow", 159'(if0.overflow), 159'(0));

    // 2: third candidate matches
    start0(32'd5);
    exp0.push_back({31'h1234, 128'hA5});
    for (int i = 0; i < 5; i++) begin
      if0.in_valid = 1'b1;
      if0.in_data = (i == 2) ? EXP : 64'(i);
      if0.in_lfsr_state = (i == 2) ? 31'h1234 : 31'(i);
      if0.in_key = (i == 2) ? 128'hA5 : 128'(i);
      tick();
      if (i == 2) chk("t2_valid_1edge", 159'(if0.res_valid), 159'(0));
      if (i == 3) begin
        chk("t2_valid_2edges", 159'(if0.res_valid), 159'(1));
        chk("t2_res_lfsr", 159'(if0.res_lfsr), 159'(31'h1234));
        chk("t2_res_key", 159'(if0.res_key), 159'(128'hA5));
      end
    end
    if0.in_valid = 1'b0;
    tick();
    chk("t2_done", 159'(if0.done), 159'(1));
    if0.res_pop = 1'b1;
    tick();
    if0.res_pop = 1'b0;
    chk("t2_empty_after_pop", 159'(if0.res_valid), 159'(0));

    // 3: six matches into a 4-deep FIFO, no pops
    start0(32'd6);
    for (int i = 0; i < 6; i++) begin
      if0.in_valid = 1'b1;
      if0.in_data = EXP;
      if0.in_lfsr_state = 31'(10 + i);
      if0.in_key = 128'(100 + i);
      if (i < 4) exp0.push_back({31'(10 + i), 128'(100 + i)});
      tick();
    end
    if0.in_valid = 1'b0;
    tick();
    chk("t3_done", 159'(if0.done), 159'(1));
    chk("t3_tested", 159'(if0.tested), 159'(6));
    chk("t3_overflow", 159'(if0.overflow), 159'(1));
    chk("t3_head_lfsr", 159'(if0.res_lfsr), 159'(31'd10));
    if0.res_pop = 1'b1;
    repeat (4) tick();
    if0.res_pop = 1'b0;
    chk("t3_empty", 159'(if0.res_valid), 159'(0));
    chk("t3_overflow_sticky", 159'(if0.overflow), 159'(1));

    // 4: push and pop together on a full FIFO
    start0(32'd5);
    chk("t4_overflow_cleared", 159'(if0.overflow), 159'(0));
    for (int i = 0; i < 5; i++) begin
      if0.in_valid = 1'b1;
      if0.in_data = EXP;
      if0.in_lfsr_state = 31'(20 + i);
      if0.in_key = 128'(200 + i);
      exp0.push_back({31'(20 + i), 128'(200 + i)});
      tick();
    end
    if0.in_valid = 1'b0;
    if0.res_pop = 1'b1;
    tick();
    if0.res_pop = 1'b0;
    chk("t4_head_advanced", 159'(if0.res_lfsr), 159'(31'd21));
    chk("t4_overflow", 159'(if0.overflow), 159'(0));
    chk("t4_done", 159'(if0.done), 159'(1));
    if0.res_pop = 1'b1;
    repeat (3) tick();
    chk("t4_last_entry_present", 159'(if0.res_valid), 159'(1));
    tick();
    if0.res_pop = 1'b0;
    chk("t4_empty_after_4", 159'(if0.res_valid), 159'(0));
    chk("t4_scoreboard_drained", 159'(exp0.size()), 159'(0));

    // 5: reset mid-search with two entries buffered
    start0(32'd100);
    for (int i = 0; i < 4; i++) begin
      if0.in_valid = 1'b1;
      if0.in_data = (i < 2) ? EXP : 64'(i);
      if0.in_lfsr_state = 31'(30 + i);
      if0.in_key = 128'(300 + i);
      tick();
    end
    chk("t5_buffered", 159'(if0.res_valid), 159'(1));
    if0.in_data = EXP;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", 159'(if0.busy), 159'(0));
    chk("t5_done", 159'(if0.done), 159'(0));
    chk("t5_tested", 159'(if0.tested), 159'(0));
    chk("t5_res_valid", 159'(if0.res_valid), 159'(0));
    repeat (3) tick();
    if0.in_valid = 1'b0;
    chk("t5_ignored_tested", 159'(if0.tested), 159'(0));
    chk("t5_ignored_res_valid", 159'(if0.res_valid), 159'(0));
    chk("t5_still_idle", 159'(if0.busy), 159'(0));

    // 6: STOP_ON_FIRST, match on the 10th candidate
    if1.max_count = 32'd100;
    if1.expected_plain = EXP;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    exp1.push_back({31'h55, 128'h77});
    for (int i = 0; i < 15; i++) begin
      if1.in_valid = 1'b1;
      if1.in_data = (i >= 9) ? EXP : 64'(i);
      if1.in_lfsr_state = (i == 9) ? 31'h55 : 31'(i);
      if1.in_key = (i == 9) ? 128'h77 : 128'(i);
      tick();
      if (i == 9) chk("t6_not_done_yet", 159'(if1.done), 159'(0));
      if (i == 10) chk("t6_done_at_push", 159'(if1.done), 159'(1));
    end
    if1.in_valid = 1'b0;
    chk("t6_tested", 159'(if1.tested), 159'(10));
    chk("t6_res_valid", 159'(if1.res_valid), 159'(1));
    chk("t6_res_lfsr", 159'(if1.res_lfsr), 159'(31'h55));
    if1.res_pop = 1'b1;
    tick();
    if1.res_pop = 1'b0;
    chk("t6_single_entry", 159'(if1.res_valid), 159'(0));
    chk("t6_scoreboard_drained", 159'(exp1.size()), 159'(0));

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
